// File: rtl/st7735s_pkg.sv
// -----------------------------------------------------------------------------
// st7735s_pkg
// Shared definitions for the ST7735s serial-link decoder:
//   - command opcodes recognised by the decoder
//   - command FSM state encoding
// -----------------------------------------------------------------------------
package st7735s_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CASET = 2'd1,
        RASET = 2'd2,
        RAMWR = 2'd3
    } state_e;

endpackage

// File: rtl/st7735s_spi_byte_rx.sv
// -----------------------------------------------------------------------------
// st7735s_spi_byte_rx
// Oversampling byte receiver for the 4-wire ST7735s link (SPI mode 0).
// Ports:
//   clk_i, rst_i   system clock, asynchronous active-high reset
//   cs_i, a0_i     chip select and command/data line (asynchronous)
//   sda_i, scl_i   serial data (MSB first) and serial clock (asynchronous)
//   byte_o, dc_o   last received byte and the A0 level captured with it
//   valid_o        one-cycle pulse when byte_o/dc_o are updated
// -----------------------------------------------------------------------------
module st7735s_spi_byte_rx
    import st7735s_pkg::*;
#(
    parameter bit CS_ACTIVE = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cs_i,
    input  logic       a0_i,
    input  logic       sda_i,
    input  logic       scl_i,
    output logic [7:0] byte_o,
    output logic       dc_o,
    output logic       valid_o
);

    logic [1:0] cs_sync_q;
    logic [1:0] a0_sync_q;
    logic [1:0] sda_sync_q;
    logic [1:0] scl_sync_q;
    logic       scl_hist_q;
    logic [6:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] byte_q;
    logic       dc_q;
    logic       valid_q;

    logic       scl_rise;
    logic       cs_sel;

    always_comb begin
        scl_rise = scl_sync_q[1] & ~scl_hist_q;
        cs_sel   = (cs_sync_q[1] == CS_ACTIVE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cs_sync_q  <= '0;
            a0_sync_q  <= '0;
            sda_sync_q <= '0;
            scl_sync_q <= '0;
            scl_hist_q <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_q     <= '0;
            dc_q       <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            cs_sync_q  <= {cs_sync_q[0],  cs_i};
            a0_sync_q  <= {a0_sync_q[0],  a0_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_sync_q <= {scl_sync_q[0], scl_i};
            scl_hist_q <= scl_sync_q[1];
            valid_q    <= 1'b0;
            if (!cs_sel) begin
                // Deselect drops any partial byte; completed bytes are untouched.
                bit_cnt_q <= '0;
            end else if (scl_rise) begin
                shift_q   <= {shift_q[5:0], sda_sync_q[1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_q  <= {shift_q, sda_sync_q[1]};
                    dc_q    <= a0_sync_q[1];
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign byte_o  = byte_q;
    assign dc_o    = dc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/st7735s_spi_decoder.sv
// -----------------------------------------------------------------------------
// st7735s_spi_decoder
// LCD-side receiver for the ST7735s serial link. Rebuilds bytes, interprets
// CASET/RASET/RAMWR/SWRESET and emits addressed pixel writes.
// Ports:
//   i_clk, i_rst                          system clock, async active-high reset
//   i_lcd_CS/A0/SDA/CLK                   serial link inputs
//   o_byte_valid, o_byte, o_byte_dc       every received byte
//   o_cmd_valid                           pulse with each command byte
//   o_pix_valid, o_pix_x/y, o_pix_data    completed pixel and its address
//   o_in_ramwr                            high while RAMWR streaming is active
// -----------------------------------------------------------------------------
module st7735s_spi_decoder
    import st7735s_pkg::*;
#(
    parameter bit          CS_ACTIVE       = 1'b0,
    parameter int unsigned BYTES_PER_PIXEL = 3,
    parameter int unsigned COORD_W         = 8,
    parameter int unsigned DEF_XE          = 127,
    parameter int unsigned DEF_YE          = 159
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_lcd_CS,
    input  logic               i_lcd_A0,
    input  logic               i_lcd_SDA,
    input  logic               i_lcd_CLK,
    output logic               o_byte_valid,
    output logic [7:0]         o_byte,
    output logic               o_byte_dc,
    output logic               o_cmd_valid,
    output logic               o_pix_valid,
    output logic [COORD_W-1:0] o_pix_x,
    output logic [COORD_W-1:0] o_pix_y,
    output logic [23:0]        o_pix_data,
    output logic               o_in_ramwr
);

    localparam logic [COORD_W-1:0] DEF_XE_C  = COORD_W'(DEF_XE);
    localparam logic [COORD_W-1:0] DEF_YE_C  = COORD_W'(DEF_YE);
    localparam logic [1:0]         LAST_BYTE = 2'(BYTES_PER_PIXEL - 1);

    logic [7:0] rx_byte;
    logic       rx_dc;
    logic       rx_valid;

    st7735s_spi_byte_rx #(
        .CS_ACTIVE (CS_ACTIVE)
    ) u_byte_rx (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .cs_i    (i_lcd_CS),
        .a0_i    (i_lcd_A0),
        .sda_i   (i_lcd_SDA),
        .scl_i   (i_lcd_CLK),
        .byte_o  (rx_byte),
        .dc_o    (rx_dc),
        .valid_o (rx_valid)
    );

    state_e             state_q,     state_d;
    logic [1:0]         byte_cnt_q,  byte_cnt_d;
    logic [15:0]        start_q,     start_d;
    logic [7:0]         end_hi_q,    end_hi_d;
    logic [COORD_W-1:0] xs_q,        xs_d;
    logic [COORD_W-1:0] xe_q,        xe_d;
    logic [COORD_W-1:0] ys_q,        ys_d;
    logic [COORD_W-1:0] ye_q,        ye_d;
    logic [COORD_W-1:0] cx_q,        cx_d;
    logic [COORD_W-1:0] cy_q,        cy_d;
    logic [23:0]        pix_acc_q,   pix_acc_d;
    logic               pix_valid_q, pix_valid_d;
    logic [COORD_W-1:0] pix_x_q,     pix_x_d;
    logic [COORD_W-1:0] pix_y_q,     pix_y_d;
    logic [23:0]        pix_data_q,  pix_data_d;

    logic [23:0]        placed;
    logic [COORD_W-1:0] end_val;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        start_d     = start_q;
        end_hi_d    = end_hi_q;
        xs_d        = xs_q;
        xe_d        = xe_q;
        ys_d        = ys_q;
        ye_d        = ye_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        pix_acc_d   = pix_acc_q;
        pix_valid_d = 1'b0;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_data_d  = pix_data_q;
        end_val     = COORD_W'({end_hi_q, rx_byte});

        // Pixel bytes land MSB-first; a 2-byte pixel leaves [7:0] at zero.
        case (byte_cnt_q)
            2'd0:    placed = {rx_byte, 16'h0000};
            2'd1:    placed = {8'h00, rx_byte, 8'h00};
            default: placed = {16'h0000, rx_byte};
        endcase

        if (rx_valid) begin
            if (!rx_dc) begin
                byte_cnt_d = '0;
                case (rx_byte)
                    CMD_CASET: state_d = CASET;
                    CMD_RASET: state_d = RASET;
                    CMD_RAMWR: begin
                        state_d = RAMWR;
                        cx_d    = xs_q;
                        cy_d    = ys_q;
                    end
                    CMD_SWRESET: begin
                        state_d = IDLE;
                        xs_d    = '0;
                        xe_d    = DEF_XE_C;
                        ys_d    = '0;
                        ye_d    = DEF_YE_C;
                    end
                    default: state_d = IDLE;
                endcase
            end else begin
                case (state_q)
                    CASET, RASET: begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: start_d[15:8] = rx_byte;
                            2'd1: start_d[7:0]  = rx_byte;
                            2'd2: end_hi_d      = rx_byte;
                            default: begin
                                // Window commits only once all four bytes are in.
                                if (state_q == CASET) begin
                                    xs_d = COORD_W'(start_q);
                                    xe_d = end_val;
                                end else begin
                                    ys_d = COORD_W'(start_q);
                                    ye_d = end_val;
                                end
                                state_d = IDLE;
                            end
                        endcase
                    end
                    RAMWR: begin
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_d  = '0;
                            pix_valid_d = 1'b1;
                            pix_x_d     = cx_q;
                            pix_y_d     = cy_q;
                            pix_data_d  = pix_acc_q | placed;
                            // Equality-only wrap: xs > xe runs through 2^COORD_W.
                            if (cx_q == xe_q) begin
                                cx_d = xs_q;
                                cy_d = (cy_q == ye_q) ? ys_q : cy_q + COORD_W'(1);
                            end else begin
                                cx_d = cx_q + COORD_W'(1);
                            end
                        end else begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            pix_acc_d  = (byte_cnt_q == 2'd0) ? placed : (pix_acc_q | placed);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            start_q     <= '0;
            end_hi_q    <= '0;
            xs_q        <= '0;
            xe_q        <= DEF_XE_C;
            ys_q        <= '0;
            ye_q        <= DEF_YE_C;
            cx_q        <= '0;
            cy_q        <= '0;
            pix_acc_q   <= '0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            start_q     <= start_d;
            end_hi_q    <= end_hi_d;
            xs_q        <= xs_d;
            xe_q        <= xe_d;
            ys_q        <= ys_d;
            ye_q        <= ye_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            pix_acc_q   <= pix_acc_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_data_q  <= pix_data_d;
        end
    end

    assign o_byte_valid = rx_valid;
    assign o_byte       = rx_byte;
    assign o_byte_dc    = rx_dc;
    assign o_cmd_valid  = rx_valid & ~rx_dc;
    assign o_pix_valid  = pix_valid_q;
    assign o_pix_x      = pix_x_q;
    assign o_pix_y      = pix_y_q;
    assign o_pix_data   = pix_data_q;
    assign o_in_ramwr   = (state_q == RAMWR);

endmodule

// File: tb/tb_st7735s_spi_decoder.sv
// -----------------------------------------------------------------------------
// tb_st7735s_spi_decoder
// Two decoders share SDA/SCL/A0; each has its own CS so only the addressed one
// sees traffic. u_a uses 3-byte pixels, u_b 2-byte pixels.
// -----------------------------------------------------------------------------
module tb_st7735s_spi_decoder;

    typedef struct {
        logic [7:0] b;
        logic       dc;
    } byte_exp_t;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [23:0] d;
    } pix_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cs_a = 1'b1;
    logic cs_b = 1'b1;
    logic a0 = 1'b0;
    logic sda = 1'b0;
    logic scl = 1'b0;

    logic        a_bv, a_dc, a_cmd, a_pv, a_ramwr;
    logic [7:0]  a_byte, a_x, a_y;
    logic [23:0] a_data;
    logic        b_bv, b_dc, b_cmd, b_pv, b_ramwr;
    logic [7:0]  b_byte, b_x, b_y;
    logic [23:0] b_data;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int a_last_bv = 0;
    int b_last_bv = 0;

    byte_exp_t qa_byte[$];
    byte_exp_t qb_byte[$];
    pix_exp_t  qa_pix[$];
    pix_exp_t  qb_pix[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    st7735s_spi_decoder #(
        .CS_ACTIVE(1'b0), .BYTES_PER_PIXEL(3), .COORD_W(8), .DEF_XE(127), .DEF_YE(159)
    ) u_a (
        .i_clk(clk), .i_rst(rst), .i_lcd_CS(cs_a), .i_lcd_A0(a0), .i_lcd_SDA(sda),
        .i_lcd_CLK(scl), .o_byte_valid(a_bv), .o_byte(a_byte), .o_byte_dc(a_dc),
        .o_cmd_valid(a_cmd), .o_pix_valid(a_pv), .o_pix_x(a_x), .o_pix_y(a_y),
        .o_pix_data(a_data), .o_in_ramwr(a_ramwr)
    );

    st7735s_spi_decoder #(
        .CS_ACTIVE(1'b0), .BYTES_PER_PIXEL(2), .COORD_W(8), .DEF_XE(127), .DEF_YE(159)
    ) u_b (
        .i_clk(clk), .i_rst(rst), .i_lcd_CS(cs_b), .i_lcd_A0(a0), .i_lcd_SDA(sda),
        .i_lcd_CLK(scl), .o_byte_valid(b_bv), .o_byte(b_byte), .o_byte_dc(b_dc),
        .o_cmd_valid(b_cmd), .o_pix_valid(b_pv), .o_pix_x(b_x), .o_pix_y(b_y),
        .o_pix_data(b_data), .o_in_ramwr(b_ramwr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard: pop an expectation for every byte/pixel either DUT produces.
    always @(negedge clk) begin
        byte_exp_t eb;
        pix_exp_t  ep;
        if (!rst) begin
            if (a_cmd && !a_bv) chk("a_cmd_without_byte", 32'd1, 32'd0);
            if (a_bv) begin
                if (qa_byte.size() == 0) chk("a_byte_unexpected", {24'd0, a_byte}, 32'hFFFF_FFFF);
                else begin
                    eb = qa_byte.pop_front();
                    chk("a_byte", {24'd0, a_byte}, {24'd0, eb.b});
                    chk("a_dc", {31'd0, a_dc}, {31'd0, eb.dc});
                    chk("a_cmd_valid", {31'd0, a_cmd}, {31'd0, ~eb.dc});
                end
                a_last_bv = cyc;
            end
            if (a_pv) begin
                if (qa_pix.size() == 0) chk("a_pix_unexpected", {8'd0, a_data}, 32'hFFFF_FFFF);
                else begin
                    ep = qa_pix.pop_front();
                    chk("a_pix_lat", cyc - a_last_bv, 32'd1);
                    chk("a_pix_x", {24'd0, a_x}, {24'd0, ep.x});
                    chk("a_pix_y", {24'd0, a_y}, {24'd0, ep.y});
                    chk("a_pix_data", {8'd0, a_data}, {8'd0, ep.d});
                end
            end
            if (b_cmd && !b_bv) chk("b_cmd_without_byte", 32'd1, 32'd0);
            if (b_bv) begin
                if (qb_byte.size() == 0) chk("b_byte_unexpected", {24'd0, b_byte}, 32'hFFFF_FFFF);
                else begin
                    eb = qb_byte.pop_front();
                    chk("b_byte", {24'd0, b_byte}, {24'd0, eb.b});
                    chk("b_dc", {31'd0, b_dc}, {31'd0, eb.dc});
                    chk("b_cmd_valid", {31'd0, b_cmd}, {31'd0, ~eb.dc});
                end
                b_last_bv = cyc;
            end
            if (b_pv) begin
                if (qb_pix.size() == 0) chk("b_pix_unexpected", {8'd0, b_data}, 32'hFFFF_FFFF);
                else begin
                    ep = qb_pix.pop_front();
                    chk("b_pix_lat", cyc - b_last_bv, 32'd1);
                    chk("b_pix_x", {24'd0, b_x}, {24'd0, ep.x});
                    chk("b_pix_y", {24'd0, b_y}, {24'd0, ep.y});
                    chk("b_pix_data", {8'd0, b_data}, {8'd0, ep.d});
                end
            end
        end
    end

    // Shift out nbits of b MSB-first, SCL high/low 2 clocks each.
    task automatic shift_bits(input bit to_b, input logic dc, input logic [7:0] b, input int nbits);
        @(negedge clk);
        cs_a = to_b;
        cs_b = !to_b;
        a0   = dc;
        for (int i = 7; i > 7 - nbits; i--) begin
            sda = b[i];
            repeat (2) @(negedge clk);
            scl = 1'b1;
            repeat (2) @(negedge clk);
            scl = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic a_send(input logic dc, input logic [7:0] b);
        qa_byte.push_back('{b: b, dc: dc});
        shift_bits(1'b0, dc, b, 8);
    endtask

    task automatic b_send(input logic dc, input logic [7:0] b);
        qb_byte.push_back('{b: b, dc: dc});
        shift_bits(1'b1, dc, b, 8);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && (qa_byte.size() + qb_byte.size() + qa_pix.size() + qb_pix.size()) != 0; i++)
            @(negedge clk);
        repeat (2) @(negedge clk);
        chk({tag, "_drain_bytes"}, qa_byte.size() + qb_byte.size(), 32'd0);
        chk({tag, "_drain_pix"}, qa_pix.size() + qb_pix.size(), 32'd0);
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_bv"},    {31'd0, a_bv},    32'd0);
        chk({tag, "_byte"},  {24'd0, a_byte},  32'd0);
        chk({tag, "_dc"},    {31'd0, a_dc},    32'd0);
        chk({tag, "_cmd"},   {31'd0, a_cmd},   32'd0);
        chk({tag, "_pv"},    {31'd0, a_pv},    32'd0);
        chk({tag, "_x"},     {24'd0, a_x},     32'd0);
        chk({tag, "_y"},     {24'd0, a_y},     32'd0);
        chk({tag, "_data"},  {8'd0, a_data},   32'd0);
        chk({tag, "_ramwr"}, {31'd0, a_ramwr}, 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_a_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // RAMWR as first command
        a_send(1'b0, 8'h2C);
        drain("t1");
        chk("t1_in_ramwr", {31'd0, a_ramwr}, 32'd1);

        // 2x2 window, 5 pixels wrap back to the window origin
        a_send(1'b0, 8'h2A);
        a_send(1'b1, 8'h00); a_send(1'b1, 8'h02); a_send(1'b1, 8'h00); a_send(1'b1, 8'h03);
        a_send(1'b0, 8'h2B);
        a_send(1'b1, 8'h00); a_send(1'b1, 8'h05); a_send(1'b1, 8'h00); a_send(1'b1, 8'h06);
        a_send(1'b0, 8'h2C);
        qa_pix.push_back('{x: 8'd2, y: 8'd5, d: 24'hFF0000});
        qa_pix.push_back('{x: 8'd3, y: 8'd5, d: 24'hFF0000});
        qa_pix.push_back('{x: 8'd2, y: 8'd6, d: 24'hFF0000});
        qa_pix.push_back('{x: 8'd3, y: 8'd6, d: 24'hFF0000});
        qa_pix.push_back('{x: 8'd2, y: 8'd5, d: 24'hFF0000});
        for (int p = 0; p < 5; p++) begin
            a_send(1'b1, 8'hFF); a_send(1'b1, 8'h00); a_send(1'b1, 8'h00);
        end
        drain("t2");

        // SWRESET, then a truncated CASET must leave the default window
        a_send(1'b0, 8'h01);
        a_send(1'b0, 8'h2A);
        a_send(1'b1, 8'h00); a_send(1'b1, 8'h07);
        a_send(1'b0, 8'h2C);
        qa_pix.push_back('{x: 8'd0, y: 8'd0, d: 24'h102030});
        qa_pix.push_back('{x: 8'd1, y: 8'd0, d: 24'hA1B2C3});
        a_send(1'b1, 8'h10); a_send(1'b1, 8'h20); a_send(1'b1, 8'h30);
        a_send(1'b1, 8'hA1); a_send(1'b1, 8'hB2); a_send(1'b1, 8'hC3);
        drain("t3");

        // Partial byte cut by CS deselect is discarded
        shift_bits(1'b0, 1'b1, 8'hA5, 5);
        cs_a = 1'b1;
        repeat (6) @(negedge clk);
        a_send(1'b0, 8'h3C);
        drain("t4");
        chk("t4_in_ramwr", {31'd0, a_ramwr}, 32'd0);

        // 2-byte pixels: pending byte dropped by SWRESET, window restored
        b_send(1'b0, 8'h2A);
        b_send(1'b1, 8'h00); b_send(1'b1, 8'h10); b_send(1'b1, 8'h00); b_send(1'b1, 8'h11);
        b_send(1'b0, 8'h2C);
        qb_pix.push_back('{x: 8'd16, y: 8'd0, d: 24'h123400});
        b_send(1'b1, 8'h12); b_send(1'b1, 8'h34); b_send(1'b1, 8'h56);
        drain("t5a");
        chk("t5_in_ramwr", {31'd0, b_ramwr}, 32'd1);
        b_send(1'b0, 8'h01);
        b_send(1'b0, 8'h2C);
        for (int p = 0; p < 129; p++) begin
            logic [7:0] v;
            v = 8'(p);
            qb_pix.push_back('{x: 8'(p % 128), y: 8'(p / 128), d: {v, ~v, 8'h00}});
            b_send(1'b1, v);
            b_send(1'b1, ~v);
        end
        drain("t5b");

        // Asynchronous reset in the middle of a pixel
        a_send(1'b0, 8'h2C);
        a_send(1'b1, 8'h11);
        drain("t6a");
        chk("t6_pre_ramwr", {31'd0, a_ramwr}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_a_zero("async_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        a_send(1'b1, 8'h22); a_send(1'b1, 8'h33); a_send(1'b1, 8'h44);
        drain("t6b");
        chk("t6_post_ramwr", {31'd0, a_ramwr}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/st7735s_spi_decoder.md
Name: st7735s_spi_decoder

Overview:
- LCD-side receiver for the 4-wire ST7735s serial link that the display controller drives (CS, A0, SDA, SCL).
- Oversamples the link on the system clock and rebuilds bytes tagged command/data.
- Interprets CASET/RASET/RAMWR/SWRESET and emits addressed pixel writes.
- Used as a panel model / frame-buffer writer in simulation and as an on-FPGA link monitor.

Parameters:
- CS_ACTIVE, 0: CS level meaning "selected"; bits are ignored while CS != CS_ACTIVE.
- BYTES_PER_PIXEL, 3: bytes per RAMWR pixel; legal values 2 or 3.
- COORD_W, 8: width of the x/y coordinate registers.
- DEF_XE, 127: window x end after reset or SWRESET.
- DEF_YE, 159: window y end after reset or SWRESET.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_lcd_CS  in  1  chip select, asynchronous to i_clk
- i_lcd_A0  in  1  0 = command, 1 = data
- i_lcd_SDA  in  1  serial data, MSB first
- i_lcd_CLK  in  1  serial clock, SPI mode 0
- o_byte_valid  out  1  one-cycle pulse per received byte
- o_byte  out  8  received byte
- o_byte_dc  out  1  A0 value captured with the byte
- o_cmd_valid  out  1  one-cycle pulse when a command byte is accepted
- o_pix_valid  out  1  one-cycle pulse per completed pixel
- o_pix_x  out  COORD_W  pixel column
- o_pix_y  out  COORD_W  pixel row
- o_pix_data  out  24  pixel value; first byte in [23:16]; for 2-byte pixels [23:8] holds the value and [7:0] = 0
- o_in_ramwr  out  1  high while RAMWR streaming is active

Behaviour:
- Reset: all outputs are 0.
  - Window is xs=0, xe=DEF_XE, ys=0, ye=DEF_YE; cursor is (0,0).
  - State is IDLE; bit counter and byte counter are 0.
- Synchronisation: CS, A0, SDA and CLK each pass through 2 flops, plus one history flop on CLK.
  - An SCL rising edge is detected on the cycle after the synced CLK goes 0->1.
  - Link requirement: SCL high and low each last >= 2 i_clk periods.
- Shifting: on each detected rising edge with synced CS == CS_ACTIVE, shift synced SDA into the shift register MSB-first and increment the 3-bit bit counter.
  - On the 8th bit, register the byte and synced A0.
  - o_byte_valid pulses exactly 1 cycle after the edge-detect cycle.
  - Bit counter wraps to 0.
- CS deselect: any cycle with CS deselected clears the bit counter and discards partial bits. Byte and pixel assembly state is kept, so CS toggling between bytes is legal.
- Command byte (dc=0): o_cmd_valid pulses in the same cycle as o_byte_valid. The byte counter is cleared. Next state:
  - 0x2A -> CASET
  - 0x2B -> RASET
  - 0x2C -> RAMWR; cursor := (xs, ys)
  - 0x01 -> IDLE; window reset to defaults
  - any other opcode -> IDLE
  - Any command aborts a partial CASET/RASET; the window keeps its old value. A partial pixel is discarded.
- Data byte in CASET or RASET: bytes 0..3 are start_hi, start_lo, end_hi, end_lo.
  - Each value is {hi,lo} truncated to COORD_W.
  - The window registers update only on the 4th byte; the state then goes to IDLE.
- Data byte in RAMWR: accumulate into a pixel.
  - On byte BYTES_PER_PIXEL-1, o_pix_valid pulses 1 cycle after that byte's o_byte_valid, with the current cursor and data.
  - Cursor advance: if x == xe then x := xs and y := (y == ye) ? ys : y+1; otherwise x := x+1, modulo 2^COORD_W.
  - Only equality is tested, so xs > xe wraps through 2^COORD_W.
- Data byte in IDLE: appears on o_byte_valid only; no other effect.
- o_in_ramwr = (state == RAMWR).
- Reset mid-byte or mid-pixel: returns to the full reset state immediately, asynchronously.

Decomposition:
- Shared package st7735s_pkg holds:
  - opcode constants CMD_SWRESET=0x01, CMD_CASET=0x2A, CMD_RASET=0x2B, CMD_RAMWR=0x2C
  - the state enum IDLE/CASET/RASET/RAMWR
- Sub-module st7735s_spi_byte_rx covers synchronisers, edge detect, shifter and CS handling.
  - It outputs the byte, dc and valid signals.
  - The top level holds the command FSM, window registers and pixel assembly.

Test Plan:
- Reset, then CS selected, A0=0, send 0x2C at 2 clk per half-bit -> o_cmd_valid and o_byte_valid=1 with o_byte=0x2C, o_byte_dc=0; o_in_ramwr=1.
- CASET 00 02 00 03, RASET 00 05 00 06, RAMWR, then 5 pixels FF 00 00 -> pixels at (2,5), (3,5), (2,6), (3,6), (2,5), each with o_pix_data=0xFF0000.
- CASET with only 2 data bytes, then RAMWR, then 1 pixel -> window unchanged; pixel at (0,0).
- CS deselected after 5 bits of 0xA5, then full byte 0x3C -> no o_byte_valid for the partial byte; next byte decodes as 0x3C.
- BYTES_PER_PIXEL=2: RAMWR, then 12 34 56 -> one pixel with o_pix_data=0x123400; 0x56 is pending; SWRESET then discards it and restores window 0..127 / 0..159.
- i_rst asserted mid-RAMWR, after 1 byte of a pixel -> all outputs 0 asynchronously; post-reset data in IDLE produces no o_pix_valid.
